// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte requesters.
// Ports: clk, rst (async active-low); per-requester req_vld/req_data/req_last
// in, req_rdy out; tx_vld/tx_data to uart_tx, tx_rdy from uart_tx;
// grant (one-hot owner) and busy status.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_vld,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_rdy,
    output logic                        tx_vld,
    output logic [DATA_WIDTH-1:0]       tx_data,
    input  logic                        tx_rdy,
    output logic [N_REQ-1:0]            grant,
    output logic                        busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TW = $clog2(IDLE_TIMEOUT);

    localparam logic [BW-1:0] BURST_END   = BW'(MAX_BURST - 1);
    localparam logic [TW-1:0] TIMEOUT_END = TW'(IDLE_TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [BW-1:0]     byte_q, byte_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic [N_REQ-1:0]  grant_q, grant_d;

    logic                  own_vld;
    logic                  own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  xfer;
    logic                  rel;
    logic                  hit;
    logic [IW-1:0]         sel;
    logic [IW-1:0]         idx;

    // Owner's signals are picked through the one-hot grant, which is
    // all-zero in IDLE, so nothing leaks through between grants.
    always_comb begin
        own_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_q[k]) begin
                own_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign own_vld  = |(grant_q & req_vld);
    assign own_last = |(grant_q & req_last);
    assign busy     = (state_q == OWN);
    assign grant    = grant_q;
    assign tx_vld   = busy && own_vld;
    assign tx_data  = tx_vld ? own_data : '0;
    assign req_rdy  = grant_q & {N_REQ{tx_rdy}};
    assign xfer     = tx_vld && tx_rdy;

    // Burst end and packet end on the same transfer collapse into one release.
    assign rel = busy &&
                 ((xfer && (own_last || byte_q == BURST_END)) ||
                  (!own_vld && idle_q == TIMEOUT_END));

    // First requester at or above rr_q, wrapping.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = IW'((int'(rr_q) + i) % N_REQ);
            if (!hit && req_vld[idx]) begin
                hit = 1'b1;
                sel = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        byte_d  = byte_q;
        idle_d  = idle_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = OWN;
                    owner_d = sel;
                    grant_d = N_REQ'(1) << sel;
                    byte_d  = '0;
                    idle_d  = '0;
                end
            end
            OWN: begin
                if (xfer) begin
                    byte_d = byte_q + 1'b1;
                end
                idle_d = own_vld ? '0 : idle_q + 1'b1;
                if (rel) begin
                    state_d = IDLE;
                    grant_d = '0;
                    byte_d  = '0;
                    idle_d  = '0;
                    rr_d    = (owner_q == IW'(N_REQ - 1)) ? '0
                                                          : owner_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            byte_q  <= '0;
            idle_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            byte_q  <= byte_d;
            idle_q  <= idle_d;
            grant_q <= grant_d;
        end
    end

endmodule
